// File: rtl/seri2pari_if.sv
// seri2pari_if -- serial receive line plus byte-stream consumer handshake.
//   inbit      serial line into the receiver (idle level 1)
//   out_valid  receive FIFO non-empty
//   out_ready  consumer accepts databyte when out_valid && out_ready at posedge clk
//   databyte   FIFO head, 0 while the FIFO is empty
//   count      bytes currently held in the FIFO (0..DEPTH)
//   frame_err  one-cycle pulse: stop bit sampled as 0
//   overflow   one-cycle pulse: good frame dropped because the FIFO was full
// Modports: slave = the receiver, master = whoever drives the line and consumes bytes.
interface seri2pari_if #(
  parameter int W     = 8,
  parameter int DEPTH = 10
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          inbit;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  databyte;
  logic [CW-1:0] count;
  logic          frame_err;
  logic          overflow;

  modport slave (
    input  inbit, out_ready,
    output out_valid, databyte, count, frame_err, overflow
  );

  modport master (
    output inbit, out_ready,
    input  out_valid, databyte, count, frame_err, overflow
  );
endinterface

// File: rtl/seri2pari.sv
// seri2pari -- serial-to-parallel receive stage.
// Samples one line bit per clk, recovers 10-bit frames (start=0, W data bits
// MSB-first, stop=1) and queues good bytes in a DEPTH-entry FIFO drained by a
// valid/ready consumer. Framing errors and FIFO overflow are one-cycle pulses.
// Ports:
//   clk    single clock, all flops on posedge
//   reset  synchronous, active-low
//   bus    seri2pari_if.slave (line input, FIFO output, status pulses)
module seri2pari #(
  parameter int DEPTH = 10,
  parameter int W     = 8
) (
  input  logic        clk,
  input  logic        reset,
  seri2pari_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int BW = $clog2(W);

  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

  state_t         state_q, state_d;
  logic [BW-1:0]  bitcnt;
  logic [W-1:0]   shreg;
  logic [PW-1:0]  rd_ptr, wr_ptr;
  logic [CW-1:0]  count;
  logic           frame_err_q, overflow_q;
  logic [W-1:0]   mem [DEPTH];

  logic shift_en, good_stop, bad_stop;
  logic full, pop, push, drop;

  // ---------------------------------------------------------------- FSM
  // NOTE: state flops use non-blocking assignment so every flop samples the
  // pre-edge values of its neighbours; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every signal written in a combinational block gets a default first,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (!bus.inbit) state_d = DATA;
      DATA: if (bitcnt == BW'(W - 1)) state_d = STOP;
      // The stop slot always returns to IDLE, so a 0 here is never a start bit.
      STOP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_en  = (state_q == DATA);
    good_stop = (state_q == STOP) &&  bus.inbit;
    bad_stop  = (state_q == STOP) && !bus.inbit;
  end

  // ----------------------------------------------------------- datapath
  assign full = (count == CW'(DEPTH));
  assign pop  = bus.out_ready && (count != '0);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push = good_stop && (!full || pop);
  assign drop = good_stop && full && !pop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      bitcnt      <= '0;
      shreg       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (state_q == IDLE) bitcnt <= '0;
      else if (shift_en)   bitcnt <= bitcnt + BW'(1);

      if (shift_en) shreg <= {shreg[W-2:0], bus.inbit};

      frame_err_q <= bad_stop;
      overflow_q  <= drop;

      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);

      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; count gates every read,
  // so stale contents are never observable and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  assign bus.out_valid = (count != '0);
  assign bus.databyte  = (count != '0) ? mem[rd_ptr] : '0;
  assign bus.count     = count;
  assign bus.frame_err = frame_err_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_seri2pari.sv
// tb_seri2pari -- self-checking bench for seri2pari.
// A byte queue models the FIFO at frame level: a good stop slot appends the
// frame's byte (if there is room after this cycle's pop), a bad stop slot
// raises frame_err, a good frame into a full queue raises overflow.
module tb_seri2pari;
  localparam int DEPTH = 10;
  localparam int W     = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seri2pari_if #(.W(W), .DEPTH(DEPTH)) bus ();

  seri2pari #(.DEPTH(DEPTH), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // reference model state
  logic [W-1:0] q[$];
  logic         exp_ferr, exp_ovf;
  logic [W-1:0] cur_byte;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_all();
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() != 0});
    check("count",     {{(32-CW){1'b0}}, bus.count}, q.size());
    check("databyte",  {24'd0, bus.databyte}, (q.size() != 0) ? {24'd0, q[0]} : 32'd0);
    check("frame_err", {31'd0, bus.frame_err}, {31'd0, exp_ferr});
    check("overflow",  {31'd0, bus.overflow},  {31'd0, exp_ovf});
  endtask

  // kind: 0 ordinary bit, 1 stop slot of a good frame (cur_byte), 2 bad stop slot
  task automatic step(input logic b, input logic rdy, input int kind);
    logic pop_m;
    bus.inbit     = b;
    bus.out_ready = rdy;
    @(posedge clk);
    pop_m    = rdy && (q.size() != 0);
    exp_ferr = (kind == 2);
    exp_ovf  = 1'b0;
    if (pop_m) void'(q.pop_front());
    if (kind == 1) begin
      if (q.size() < DEPTH) q.push_back(cur_byte);
      else                  exp_ovf = 1'b1;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset(input int n);
    bus.inbit     = 1'b1;
    bus.out_ready = 1'b0;
    reset         = 1'b0;
    repeat (n) begin
      @(posedge clk);
      q.delete();
      exp_ferr = 1'b0;
      exp_ovf  = 1'b0;
      @(negedge clk);
      check_all();
    end
    reset = 1'b1;
  endtask

  // rmode: 0 ready low, 1 ready high, 2 random, 3 high only in the stop slot
  function automatic logic rdy_of(input int rmode, input bit stop_slot);
    case (rmode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return 1'($urandom_range(0, 1));
      default: return stop_slot;
    endcase
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic sb, input int rmode);
    cur_byte = b;
    step(1'b0, rdy_of(rmode, 0), 0);
    for (int i = W - 1; i >= 0; i--) step(b[i], rdy_of(rmode, 0), 0);
    step(sb, rdy_of(rmode, 1), sb ? 1 : 2);
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) step(1'b1, rdy, 0);
  endtask

  initial begin
    exp_ferr = 1'b0;
    exp_ovf  = 1'b0;
    cur_byte = '0;

    // 1: reset, then long idle
    do_reset(3);
    idle(20, 1'b0);

    // 2: single frame 0xA5
    send_frame(8'hA5, 1'b1, 0);
    check("t2_byte", {24'd0, bus.databyte}, 32'hA5);
    idle(3, 1'b1);

    // 3: fill, overflow, drain
    for (int i = 0; i < 10; i++) send_frame(8'(i), 1'b1, 0);
    check("t3_full", {{(32-CW){1'b0}}, bus.count}, 32'd10);
    send_frame(8'hFF, 1'b1, 0);
    check("t3_ovf", {31'd0, bus.overflow}, 32'd1);
    idle(12, 1'b1);
    check("t3_empty", {{(32-CW){1'b0}}, bus.count}, 32'd0);

    // 4: framing error, then a back-to-back good frame
    send_frame(8'h3C, 1'b0, 0);
    check("t4_ferr", {31'd0, bus.frame_err}, 32'd1);
    send_frame(8'h81, 1'b1, 0);
    check("t4_byte", {24'd0, bus.databyte}, 32'h81);
    idle(3, 1'b1);

    // 5: full FIFO, push and pop in the same cycle
    for (int i = 0; i < 10; i++) send_frame(8'h10 + 8'(i), 1'b1, 0);
    send_frame(8'h55, 1'b1, 3);
    check("t5_cnt", {{(32-CW){1'b0}}, bus.count}, 32'd10);
    idle(12, 1'b1);

    // 6: reset in the middle of a frame
    send_frame(8'hC3, 1'b1, 0);
    send_frame(8'h24, 1'b1, 0);
    step(1'b0, 1'b0, 0);
    for (int i = W - 1; i >= W - 4; i--) step(1'($unsigned(8'h99 >> i)), 1'b0, 0);
    do_reset(1);
    idle(2, 1'b0);
    send_frame(8'h7E, 1'b1, 0);
    check("t6_byte", {24'd0, bus.databyte}, 32'h7E);
    idle(2, 1'b1);

    // randomized traffic: random bytes, occasional bad stop bits, random ready
    for (int f = 0; f < 40; f++) begin
      send_frame(8'($urandom), ($urandom_range(0, 7) != 0), 2);
      idle($urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    idle(15, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
